dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port byte-addressed data memory between the pipeline MEM stage (core port) and a DMA/debug loader port (dma port).
- Grants one 32-bit word access per cycle. Core has fixed priority, with a starvation guard for the DMA port.
- Drives the data memory's address, writeData, memRead and memWrite inputs and consumes its combinational read data.
- Returns registered responses and a stall to the hazard unit.

Parameters:
- ADDR_W, 32: request/memory address width.
- DATA_W, 32: data width.
- MEM_BYTES, 128: memory size in bytes; used for bounds check.
- STARVE_LIMIT, 4: consecutive denied DMA cycles before DMA is forced to win; range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- core_req_valid  in  1  MEM-stage access request
- core_req_we  in  1  1=store, 0=load
- core_req_addr  in  ADDR_W  byte address
- core_req_wdata  in  DATA_W  store data
- core_req_ready  out  1  core request accepted this cycle
- core_stall  out  1  core_req_valid & ~core_req_ready
- core_rsp_valid  out  1  load data valid (registered)
- core_rsp_rdata  out  DATA_W  load data
- core_rsp_err  out  1  request suppressed (bounds/alignment)
- dma_req_valid  in  1  DMA request
- dma_req_we  in  1  1=write, 0=read
- dma_req_addr  in  ADDR_W  byte address
- dma_req_wdata  in  DATA_W  write data
- dma_req_ready  out  1  DMA request accepted this cycle
- dma_rsp_valid  out  1  read data valid (registered)
- dma_rsp_rdata  out  DATA_W  read data
- dma_rsp_err  out  1  request suppressed
- mem_address  out  ADDR_W  to data memory
- mem_writeData  out  DATA_W  to data memory
- mem_memRead  out  1  to data memory
- mem_memWrite  out  1  to data memory
- mem_memData  in  DATA_W  combinational read data from data memory

Behaviour:
- Clock is clk. Reset is synchronous, active-high, named reset; it is sampled only at the posedge of clk.
- While reset is high:
  - core_req_ready, dma_req_ready and all mem_* outputs are forced to 0.
  - At the clock edge: rsp_valid/rdata/err of both ports clear to 0, starve_cnt clears to 0, last_grant clears to CORE.
- Arbitration is combinational each cycle:
  - dma_force = dma_req_valid & (starve_cnt == STARVE_LIMIT).
  - If dma_force: grant DMA.
  - Else if core_req_valid: grant CORE.
  - Else if dma_req_valid: grant DMA.
  - Else: no grant.
- The granted port's ready = 1; the other port's ready = 0. At most one ready is high per cycle.
- Granted request that is legal:
  - mem_address and mem_writeData are driven from the granted port.
  - mem_memWrite = we; mem_memRead = ~we.
  - The memory commits the write at the same posedge.
- Legal means (addr + 3) < MEM_BYTES, computed in ADDR_W+1 bits so it cannot wrap.
- Illegal request:
  - Still accepted (ready=1), but mem_memRead = mem_memWrite = 0.
  - Next cycle: that port's rsp_valid=1, err=1, rdata=0.
  - This applies to both loads and stores.
- Response timing: one cycle latency.
  - A legal read granted in cycle N has rsp_valid=1 and rdata=mem_memData(N) in cycle N+1.
  - Legal writes produce no rsp_valid.
  - rsp_valid is high for exactly one cycle per accepted read; there is no backpressure on responses.
- Idle: no grant means all mem_* outputs are 0.
- starve_cnt (4 bits):
  - Increments when dma_req_valid & ~dma_req_ready, saturating at STARVE_LIMIT.
  - Clears when the DMA is granted or dma_req_valid is low.
- last_grant register records the port granted in the previous cycle. It is held when there is no grant and is used for the starvation assertion in verification.
- Simultaneous core and DMA access to the same address: the order is the grant order. A core read following a DMA write in the next cycle sees the new data.
- Reset asserted mid-request: the request is dropped, no memory side effect, no response.
- core_stall is purely combinational; the pipeline holds MEM/WB while it is high.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined: a request with addr[1:0] != 0 is treated as illegal (suppressed, err response as above).
- Undefined: alignment is not checked; only the bounds check applies, and misaligned legal accesses go to memory unchanged.

Decomposition:
- Package dmem_arb_pkg holds:
  - typedef enum logic {GRANT_CORE, GRANT_DMA} grant_e
  - typedef struct req_t {we, addr, wdata}
  - localparam STARVE_CNT_W = 4
- One natural sub-module: dmem_req_check (combinational bounds/alignment legality of one request), instantiated twice.

Test Plan:
1. Core store addr 8 wdata 0xDEADBEEF, then core load addr 8 -> store cycle: ready=1, memWrite=1; load cycle+1: core_rsp_valid=1, rdata=0xDEADBEEF, err=0.
2. Core and DMA both valid continuously, STARVE_LIMIT=4 -> core granted 4 cycles, DMA granted on cycle 5, starve_cnt then back to 0; pattern repeats; core_stall=1 only in the DMA cycles.
3. DMA write addr 0x10 = 0x11223344 in cycle N; core read addr 0x10 in N+1 -> core_rsp_rdata=0x11223344 at N+2.
4. Core load addr 126 (MEM_BYTES=128) -> ready=1, memRead=0; next cycle rsp_valid=1, err=1, rdata=0. Load addr 124 -> err=0.
5. With DMEM_ALIGN_CHECK_EN defined: DMA write addr 0x21 -> memWrite=0; next cycle dma_rsp_valid=1, err=1. Without the macro: memWrite=1 and no response.
6. Reset asserted while both ports are valid -> readies=0, mem_* outputs=0, no write; cycle after reset: rsp_valid=0, starve_cnt=0, core granted first.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter (core MEM stage vs. DMA/debug loader).
package dmem_arb_pkg;

    localparam int STARVE_CNT_W = 4;
    localparam int REQ_ADDR_W   = 32;
    localparam int REQ_DATA_W   = 32;

    typedef enum logic {
        GRANT_CORE = 1'b0,
        GRANT_DMA  = 1'b1
    } grant_e;

    typedef struct packed {
        logic                  we;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/dmem_req_check.sv
// Combinational legality check for one word request: the whole 4-byte word must fit inside
// the memory. Optional macro DMEM_ALIGN_CHECK_EN additionally rejects addresses that are not
// word aligned; without it, misaligned in-bounds accesses are passed through unchanged.
module dmem_req_check #(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 128
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic              legal_o
);

    logic [ADDR_W:0] last_byte;

    // Bounds check done one bit wider so an address near the top of the space cannot wrap.
    always_comb begin
        last_byte = {1'b0, addr_i} + (ADDR_W+1)'(3);
        legal_o   = (last_byte < (ADDR_W+1)'(MEM_BYTES));
`ifdef DMEM_ALIGN_CHECK_EN
        if (addr_i[1:0] != 2'b00) begin
            legal_o = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data memory between the core MEM stage and the DMA port.
// Core has fixed priority; DMA is forced through after STARVE_LIMIT consecutive denials.
// Responses are registered (one-cycle latency). Optional macro: DMEM_ALIGN_CHECK_EN (see dmem_req_check).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_BYTES    = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req_valid,
    input  logic              core_req_we,
    input  logic [ADDR_W-1:0] core_req_addr,
    input  logic [DATA_W-1:0] core_req_wdata,
    output logic              core_req_ready,
    output logic              core_stall,
    output logic              core_rsp_valid,
    output logic [DATA_W-1:0] core_rsp_rdata,
    output logic              core_rsp_err,
    input  logic              dma_req_valid,
    input  logic              dma_req_we,
    input  logic [ADDR_W-1:0] dma_req_addr,
    input  logic [DATA_W-1:0] dma_req_wdata,
    output logic              dma_req_ready,
    output logic              dma_rsp_valid,
    output logic [DATA_W-1:0] dma_rsp_rdata,
    output logic              dma_rsp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writeData,
    output logic              mem_memRead,
    output logic              mem_memWrite,
    input  logic [DATA_W-1:0] mem_memData
);

    localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = STARVE_CNT_W'(STARVE_LIMIT);

    logic                    core_legal;
    logic                    dma_legal;
    logic                    dma_force;
    logic                    grant_any;
    grant_e                  grant_sel;
    logic                    sel_we;
    logic [ADDR_W-1:0]       sel_addr;
    logic [DATA_W-1:0]       sel_wdata;
    logic                    sel_legal;

    logic [STARVE_CNT_W-1:0] starve_q, starve_d;
    grant_e                  last_grant_q, last_grant_d;
    logic                    core_rsp_valid_q, core_rsp_valid_d;
    logic [DATA_W-1:0]       core_rsp_rdata_q, core_rsp_rdata_d;
    logic                    core_rsp_err_q, core_rsp_err_d;
    logic                    dma_rsp_valid_q, dma_rsp_valid_d;
    logic [DATA_W-1:0]       dma_rsp_rdata_q, dma_rsp_rdata_d;
    logic                    dma_rsp_err_q, dma_rsp_err_d;

    dmem_req_check #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) u_core_check (
        .addr_i  (core_req_addr),
        .legal_o (core_legal)
    );

    dmem_req_check #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) u_dma_check (
        .addr_i  (dma_req_addr),
        .legal_o (dma_legal)
    );

    // Pick the winner for this cycle: starved DMA first, then core, then DMA; nobody during reset.
    always_comb begin
        grant_any = 1'b0;
        grant_sel = GRANT_CORE;
        dma_force = dma_req_valid && (starve_q == STARVE_MAX);
        if (!reset) begin
            if (dma_force) begin
                grant_any = 1'b1;
                grant_sel = GRANT_DMA;
            end else if (core_req_valid) begin
                grant_any = 1'b1;
                grant_sel = GRANT_CORE;
            end else if (dma_req_valid) begin
                grant_any = 1'b1;
                grant_sel = GRANT_DMA;
            end
        end
        core_req_ready = grant_any && (grant_sel == GRANT_CORE);
        dma_req_ready  = grant_any && (grant_sel == GRANT_DMA);
        core_stall     = core_req_valid && !core_req_ready;
    end

    // Steer the winning request onto the memory; illegal or absent requests leave the memory untouched.
    always_comb begin
        sel_we        = (grant_sel == GRANT_DMA) ? dma_req_we    : core_req_we;
        sel_addr      = (grant_sel == GRANT_DMA) ? dma_req_addr  : core_req_addr;
        sel_wdata     = (grant_sel == GRANT_DMA) ? dma_req_wdata : core_req_wdata;
        sel_legal     = (grant_sel == GRANT_DMA) ? dma_legal     : core_legal;
        mem_address   = '0;
        mem_writeData = '0;
        mem_memRead   = 1'b0;
        mem_memWrite  = 1'b0;
        if (grant_any && sel_legal) begin
            mem_address   = sel_addr;
            mem_writeData = sel_wdata;
            mem_memRead   = !sel_we;
            mem_memWrite  = sel_we;
        end
    end

    // Next-state for responses, starvation counter and last grant.
    always_comb begin
        core_rsp_valid_d = 1'b0;
        core_rsp_rdata_d = '0;
        core_rsp_err_d   = 1'b0;
        dma_rsp_valid_d  = 1'b0;
        dma_rsp_rdata_d  = '0;
        dma_rsp_err_d    = 1'b0;
        last_grant_d     = last_grant_q;
        starve_d         = starve_q;

        if (grant_any) begin
            last_grant_d = grant_sel;
            if (grant_sel == GRANT_CORE) begin
                core_rsp_valid_d = !sel_legal || !sel_we;
                core_rsp_err_d   = !sel_legal;
                core_rsp_rdata_d = (sel_legal && !sel_we) ? mem_memData : '0;
            end else begin
                dma_rsp_valid_d  = !sel_legal || !sel_we;
                dma_rsp_err_d    = !sel_legal;
                dma_rsp_rdata_d  = (sel_legal && !sel_we) ? mem_memData : '0;
            end
        end

        if (!dma_req_valid || dma_req_ready) begin
            starve_d = '0;
        end else if (starve_q < STARVE_MAX) begin
            starve_d = starve_q + STARVE_CNT_W'(1);
        end
    end

    // State registers with synchronous reset; a request in flight during reset is simply dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q         <= '0;
            last_grant_q     <= GRANT_CORE;
            core_rsp_valid_q <= 1'b0;
            core_rsp_rdata_q <= '0;
            core_rsp_err_q   <= 1'b0;
            dma_rsp_valid_q  <= 1'b0;
            dma_rsp_rdata_q  <= '0;
            dma_rsp_err_q    <= 1'b0;
        end else begin
            starve_q         <= starve_d;
            last_grant_q     <= last_grant_d;
            core_rsp_valid_q <= core_rsp_valid_d;
            core_rsp_rdata_q <= core_rsp_rdata_d;
            core_rsp_err_q   <= core_rsp_err_d;
            dma_rsp_valid_q  <= dma_rsp_valid_d;
            dma_rsp_rdata_q  <= dma_rsp_rdata_d;
            dma_rsp_err_q    <= dma_rsp_err_d;
        end
    end

    // A saturated starvation count can only follow a cycle in which the core won.
    always @(posedge clk) begin
        if (!reset && (starve_q == STARVE_MAX)) begin
            assert (last_grant_q == GRANT_CORE);
        end
    end

    assign core_rsp_valid = core_rsp_valid_q;
    assign core_rsp_rdata = core_rsp_rdata_q;
    assign core_rsp_err   = core_rsp_err_q;
    assign dma_rsp_valid  = dma_rsp_valid_q;
    assign dma_rsp_rdata  = dma_rsp_rdata_q;
    assign dma_rsp_err    = dma_rsp_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random traffic,
// compared cycle by cycle against a behavioural model with its own copy of memory.
module tb_dmem_arbiter;

    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int MEM_BYTES    = 128;
    localparam int STARVE_LIMIT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              core_req_valid, core_req_we;
    logic [ADDR_W-1:0] core_req_addr;
    logic [DATA_W-1:0] core_req_wdata;
    logic              core_req_ready, core_stall, core_rsp_valid, core_rsp_err;
    logic [DATA_W-1:0] core_rsp_rdata;
    logic              dma_req_valid, dma_req_we;
    logic [ADDR_W-1:0] dma_req_addr;
    logic [DATA_W-1:0] dma_req_wdata;
    logic              dma_req_ready, dma_rsp_valid, dma_rsp_err;
    logic [DATA_W-1:0] dma_rsp_rdata;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_writeData;
    logic              mem_memRead, mem_memWrite;
    logic [DATA_W-1:0] mem_memData;

    logic [7:0] envMem [MEM_BYTES];
    logic [7:0] refMem [MEM_BYTES];
    int         envAddr;

    int errCount = 0;
    int checkCount = 0;

    int          deniedRun = 0;
    bit          respKnown = 0;
    bit          expCoreRspValid = 0, expCoreRspErr = 0;
    bit          expDmaRspValid = 0, expDmaRspErr = 0;
    logic [31:0] expCoreRspData = '0, expDmaRspData = '0;

    dmem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BYTES(MEM_BYTES), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .core_req_valid(core_req_valid), .core_req_we(core_req_we),
        .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata),
        .core_req_ready(core_req_ready), .core_stall(core_stall),
        .core_rsp_valid(core_rsp_valid), .core_rsp_rdata(core_rsp_rdata), .core_rsp_err(core_rsp_err),
        .dma_req_valid(dma_req_valid), .dma_req_we(dma_req_we),
        .dma_req_addr(dma_req_addr), .dma_req_wdata(dma_req_wdata),
        .dma_req_ready(dma_req_ready),
        .dma_rsp_valid(dma_rsp_valid), .dma_rsp_rdata(dma_rsp_rdata), .dma_rsp_err(dma_rsp_err),
        .mem_address(mem_address), .mem_writeData(mem_writeData),
        .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite), .mem_memData(mem_memData)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Data memory seen by the DUT: combinational little-endian word read.
    always_comb begin
        envAddr     = int'(mem_address);
        mem_memData = '0;
        if (mem_address <= ADDR_W'(MEM_BYTES - 4)) begin
            mem_memData = {envMem[envAddr+3], envMem[envAddr+2], envMem[envAddr+1], envMem[envAddr]};
        end
    end

    // Data memory write port: commits at the clock edge when the DUT asks for it.
    always @(posedge clk) begin
        if (mem_memWrite && mem_address <= ADDR_W'(MEM_BYTES - 4)) begin
            envMem[envAddr]   <= mem_writeData[7:0];
            envMem[envAddr+1] <= mem_writeData[15:8];
            envMem[envAddr+2] <= mem_writeData[23:16];
            envMem[envAddr+3] <= mem_writeData[31:24];
        end
    end

    function automatic bit isLegal(logic [31:0] addr);
        longint lastByte;
        bit ok;
        lastByte = longint'(addr) + 3;
        ok = (lastByte < MEM_BYTES);
`ifdef DMEM_ALIGN_CHECK_EN
        if ((addr % 4) != 0) ok = 0;
`endif
        return ok;
    endfunction

    function automatic logic [31:0] refRead(logic [31:0] addr);
        int a;
        a = int'(addr);
        return {refMem[a+3], refMem[a+2], refMem[a+1], refMem[a]};
    endfunction

    function automatic logic [31:0] randAddr();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return $urandom;
        if (r == 1) return 32'(124 + $urandom_range(0, 7));
        return 32'($urandom_range(0, 31) * 4 + (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit cv, input bit cwe, input logic [31:0] ca,
                                 input logic [31:0] cw, input bit dv, input bit dwe,
                                 input logic [31:0] da, input logic [31:0] dw);
        reset          = rst;
        core_req_valid = cv;
        core_req_we    = cwe;
        core_req_addr  = ca;
        core_req_wdata = cw;
        dma_req_valid  = dv;
        dma_req_we     = dwe;
        dma_req_addr   = da;
        dma_req_wdata  = dw;
    endtask

    task automatic runCycle(input bit rst, input bit cv, input bit cwe, input logic [31:0] ca,
                            input logic [31:0] cw, input bit dv, input bit dwe,
                            input logic [31:0] da, input logic [31:0] dw);
        bit gCore, gDma, legal, selWe, expRead, expWrite;
        logic [31:0] selAddr, selWd;
        int a;
        @(negedge clk);
        if (respKnown) begin
            checkOutput("core_rsp_valid", 32'(core_rsp_valid), 32'(expCoreRspValid));
            checkOutput("dma_rsp_valid", 32'(dma_rsp_valid), 32'(expDmaRspValid));
            if (expCoreRspValid) begin
                checkOutput("core_rsp_err", 32'(core_rsp_err), 32'(expCoreRspErr));
                checkOutput("core_rsp_rdata", core_rsp_rdata, expCoreRspData);
            end
            if (expDmaRspValid) begin
                checkOutput("dma_rsp_err", 32'(dma_rsp_err), 32'(expDmaRspErr));
                checkOutput("dma_rsp_rdata", dma_rsp_rdata, expDmaRspData);
            end
        end
        applyStimulus(rst, cv, cwe, ca, cw, dv, dwe, da, dw);
        #1;
        gCore = 0;
        gDma  = 0;
        if (!rst) begin
            if (dv && deniedRun == STARVE_LIMIT) gDma = 1;
            else if (cv) gCore = 1;
            else if (dv) gDma = 1;
        end
        selWe    = gDma ? dwe : cwe;
        selAddr  = gDma ? da : ca;
        selWd    = gDma ? dw : cw;
        legal    = isLegal(selAddr);
        expRead  = (gCore || gDma) && legal && !selWe;
        expWrite = (gCore || gDma) && legal && selWe;
        checkOutput("core_req_ready", 32'(core_req_ready), 32'(gCore));
        checkOutput("dma_req_ready", 32'(dma_req_ready), 32'(gDma));
        checkOutput("core_stall", 32'(core_stall), 32'(cv && !gCore));
        checkOutput("mem_memRead", 32'(mem_memRead), 32'(expRead));
        checkOutput("mem_memWrite", 32'(mem_memWrite), 32'(expWrite));
        if (expRead || expWrite) checkOutput("mem_address", mem_address, selAddr);
        if (expWrite) checkOutput("mem_writeData", mem_writeData, selWd);
        if (!gCore && !gDma) begin
            checkOutput("mem_address_idle", mem_address, 32'd0);
            checkOutput("mem_writeData_idle", mem_writeData, 32'd0);
        end

        expCoreRspValid = 0; expCoreRspErr = 0; expCoreRspData = '0;
        expDmaRspValid  = 0; expDmaRspErr  = 0; expDmaRspData  = '0;
        if ((gCore || gDma) && (!legal || !selWe)) begin
            if (gCore) begin
                expCoreRspValid = 1;
                expCoreRspErr   = !legal;
                expCoreRspData  = legal ? refRead(selAddr) : 32'd0;
            end else begin
                expDmaRspValid  = 1;
                expDmaRspErr    = !legal;
                expDmaRspData   = legal ? refRead(selAddr) : 32'd0;
            end
        end
        if (expWrite) begin
            a = int'(selAddr);
            refMem[a]   = selWd[7:0];
            refMem[a+1] = selWd[15:8];
            refMem[a+2] = selWd[23:16];
            refMem[a+3] = selWd[31:24];
        end
        if (rst || !dv || gDma) deniedRun = 0;
        else if (deniedRun < STARVE_LIMIT) deniedRun++;
        if (rst) respKnown = 1;
    endtask

    task automatic idleCycle();
        runCycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Directed scenarios, then random traffic with occasional resets.
    initial begin
        logic [7:0] b;
        for (int i = 0; i < MEM_BYTES; i++) begin
            b = 8'($urandom);
            envMem[i] = b;
            refMem[i] = b;
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

        runCycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycle(1, 1, 1, 32'h8, 32'h5555_5555, 1, 1, 32'h8, 32'h6666_6666);

        $display("[TB] core store then load");
        runCycle(0, 1, 1, 32'h8, 32'hDEAD_BEEF, 0, 0, 0, 0);
        runCycle(0, 1, 0, 32'h8, 0, 0, 0, 0, 0);
        idleCycle();

        $display("[TB] starvation pattern");
        for (int i = 0; i < 12; i++) begin
            runCycle(0, 1, 0, 32'(4 * (i % 8)), 0, 1, 0, 32'(64 + 4 * (i % 8)), 0);
        end
        idleCycle();

        $display("[TB] dma write followed by core read");
        runCycle(0, 0, 0, 0, 0, 1, 1, 32'h10, 32'h1122_3344);
        runCycle(0, 1, 0, 32'h10, 0, 0, 0, 0, 0);
        idleCycle();

        $display("[TB] bounds");
        runCycle(0, 1, 0, 32'd126, 0, 0, 0, 0, 0);
        runCycle(0, 1, 0, 32'd124, 0, 0, 0, 0, 0);
        runCycle(0, 1, 1, 32'd125, 32'hCAFE_F00D, 0, 0, 0, 0);
        runCycle(0, 1, 0, 32'hFFFF_FFFE, 0, 0, 0, 0, 0);
        idleCycle();

        $display("[TB] misaligned dma write");
        runCycle(0, 0, 0, 0, 0, 1, 1, 32'h21, 32'hA5A5_5A5A);
        runCycle(0, 0, 0, 0, 0, 1, 0, 32'h20, 0);
        idleCycle();

        $display("[TB] reset mid-request");
        runCycle(0, 1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
        runCycle(1, 1, 1, 32'h0, 32'h1234_5678, 1, 1, 32'h4, 32'h8765_4321);
        runCycle(0, 1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
        runCycle(0, 0, 0, 0, 0, 1, 0, 32'h4, 0);
        idleCycle();

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            runCycle(($urandom_range(0, 59) == 0),
                     ($urandom_range(0, 3) != 0), 1'($urandom), randAddr(), $urandom,
                     ($urandom_range(0, 2) != 0), 1'($urandom), randAddr(), $urandom);
        end
        idleCycle();
        idleCycle();

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
